// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming frame controller.
// Holds the FSM encoding, codeword widths and a saturating counter helper.
package hamming_pkg;

    localparam int CW_W   = 15;
    localparam int DATA_W = 11;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    // Adds 0..2 to a counter and clamps at all-ones.
    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0] a,
        input logic [1:0]       inc
    );
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/hamming_out_fifo.sv
// Single-clock output FIFO with separate occupancy counter.
// A push on a full FIFO only succeeds when a pop happens in the same cycle.
module hamming_out_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop;
    logic             push_en;

    always_comb begin
        out_valid = (count_q != '0);
        out_data  = mem_q[rd_ptr_q];
        full      = (count_q == (AW+1)'(DEPTH));
        pop       = out_valid && pop_ready;
        push_en   = push && (!full || pop);
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_en, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hamming_frame_ctrl.sv
// Sequences received codewords through an external Hamming decoder
// and buffers the corrected data words for a ready/valid consumer.
module hamming_frame_ctrl
    import hamming_pkg::*;
#(
    parameter int DEC_LAT    = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_ctl,
    input  logic              rst_ctl,
    input  logic              rx_valid_ctl,
    input  logic [CW_W-1:0]   rx_data_ctl,
    output logic [CW_W-1:0]   dec_in_ctl,
    output logic              dec_start_ctl,
    input  logic [DATA_W-1:0] dec_out_ctl,
    output logic              out_valid_ctl,
    input  logic              out_ready_ctl,
    output logic [DATA_W-1:0] out_data_ctl,
    output logic [CNT_W-1:0]  ok_cnt_ctl,
    output logic [CNT_W-1:0]  drop_cnt_ctl,
    output logic              busy_ctl
);

    localparam logic [2:0] LAT3 = 3'(DEC_LAT);

    state_e            state_q, state_d;
    logic [CW_W-1:0]   dec_in_q, dec_in_d;
    logic [2:0]        wait_q, wait_d;
    logic              pend_v_q, pend_v_d;
    logic [CW_W-1:0]   pend_q, pend_d;
    logic [CNT_W-1:0]  ok_q, ok_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              store;
    logic              pend_drop;
    logic              fifo_drop;
    logic              fifo_full;
    logic              push_ok;
    logic              pop;

    always_comb begin
        state_d   = state_q;
        dec_in_d  = dec_in_q;
        wait_d    = wait_q;
        pend_v_d  = pend_v_q;
        pend_d    = pend_q;
        store     = 1'b0;
        pend_drop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rx_valid_ctl) begin
                    dec_in_d = rx_data_ctl;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wait_d  = LAT3;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q <= 3'd1) begin
                    state_d = ST_STORE;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            ST_STORE: begin
                store = 1'b1;
                if (pend_v_q) begin
                    dec_in_d = pend_q;
                    pend_v_d = 1'b0;
                    state_d  = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Fullness is judged on the registered flag, so a strobe in
        // STORE is still dropped while the pending word is handed off.
        if (state_q != ST_IDLE && rx_valid_ctl) begin
            if (!pend_v_q) begin
                pend_v_d = 1'b1;
                pend_d   = rx_data_ctl;
            end else begin
                pend_drop = 1'b1;
            end
        end
        pop       = out_valid_ctl && out_ready_ctl;
        push_ok   = store && (!fifo_full || pop);
        fifo_drop = store && fifo_full && !pop;
        ok_d      = sat_add(ok_q, {1'b0, push_ok});
        drop_d    = sat_add(drop_q,
                            {1'b0, pend_drop} + {1'b0, fifo_drop});
    end

    always_ff @(posedge clk_ctl) begin
        if (rst_ctl) begin
            state_q  <= ST_IDLE;
            dec_in_q <= '0;
            wait_q   <= '0;
            pend_v_q <= 1'b0;
            pend_q   <= '0;
            ok_q     <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            dec_in_q <= dec_in_d;
            wait_q   <= wait_d;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            ok_q     <= ok_d;
            drop_q   <= drop_d;
        end
    end

    hamming_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk_ctl),
        .rst       (rst_ctl),
        .push      (store),
        .push_data (dec_out_ctl),
        .pop_ready (out_ready_ctl),
        .out_valid (out_valid_ctl),
        .out_data  (out_data_ctl),
        .full      (fifo_full)
    );

    assign dec_in_ctl    = dec_in_q;
    assign dec_start_ctl = (state_q == ST_LOAD);
    assign busy_ctl      = (state_q != ST_IDLE);
    assign ok_cnt_ctl    = ok_q;
    assign drop_cnt_ctl  = drop_q;

endmodule

// File: tb/tb_hamming_frame_ctrl.sv
// Directed bench for hamming_frame_ctrl with a one-cycle stub decoder.
module tb_hamming_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_valid = 1'b0;
    logic [14:0] rx_data = '0;
    logic [14:0] dec_in;
    logic        dec_start;
    logic [10:0] dec_out = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] out_data;
    logic [7:0]  ok_cnt;
    logic [7:0]  drop_cnt;
    logic        busy;

    int errs = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic [10:0] got [$];

    always #5 clk = ~clk;

    always @(posedge clk) dec_out <= dec_in[10:0];

    always @(negedge clk)
        if (mon_en && out_valid && out_ready) got.push_back(out_data);

    hamming_frame_ctrl #(.DEC_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk_ctl       (clk),
        .rst_ctl       (rst),
        .rx_valid_ctl  (rx_valid),
        .rx_data_ctl   (rx_data),
        .dec_in_ctl    (dec_in),
        .dec_start_ctl (dec_start),
        .dec_out_ctl   (dec_out),
        .out_valid_ctl (out_valid),
        .out_ready_ctl (out_ready),
        .out_data_ctl  (out_data),
        .ok_cnt_ctl    (ok_cnt),
        .drop_cnt_ctl  (drop_cnt),
        .busy_ctl      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] val(input int i);
        return 11'((i * 37 + 5) & 32'h7FF);
    endfunction

    function automatic logic [14:0] cw(input int i);
        return {4'(i), val(i)};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [14:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        // reset values
        rst = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ok", 32'(ok_cnt), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_decin", 32'(dec_in), 0);
        chk("rst_start", 32'(dec_start), 0);
        rst = 1'b0;

        // single word latency
        send(15'h1234);
        chk("lat_start1", 32'(dec_start), 1);
        chk("lat_decin", 32'(dec_in), 32'h1234);
        chk("lat_busy", 32'(busy), 1);
        tick();
        chk("lat_start2", 32'(dec_start), 0);
        tick();
        chk("lat_valid3", 32'(out_valid), 0);
        tick();
        chk("lat_valid4", 32'(out_valid), 1);
        chk("lat_data", 32'(out_data), 32'h234);
        chk("lat_ok", 32'(ok_cnt), 1);
        out_ready = 1'b1;
        tick();
        chk("lat_popped", 32'(out_valid), 0);
        out_ready = 1'b0;

        // three back-to-back strobes
        do_reset();
        rx_valid = 1'b1;
        rx_data = 15'h7A01;
        tick();
        rx_data = 15'h0555;
        tick();
        rx_data = 15'h2FFF;
        tick();
        rx_valid = 1'b0;
        wait_idle(20);
        chk("b2b_drop", 32'(drop_cnt), 1);
        chk("b2b_ok", 32'(ok_cnt), 2);
        chk("b2b_validA", 32'(out_valid), 1);
        chk("b2b_dataA", 32'(out_data), 32'h201);
        out_ready = 1'b1;
        tick();
        chk("b2b_validB", 32'(out_valid), 1);
        chk("b2b_dataB", 32'(out_data), 32'h555);
        tick();
        chk("b2b_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // overflow with no consumer
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(cw(i));
            wait_idle(20);
        end
        chk("ovf_ok", 32'(ok_cnt), 4);
        chk("ovf_drop", 32'(drop_cnt), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("ovf_valid", 32'(out_valid), 1);
            chk("ovf_data", 32'(out_data), 32'(val(i)));
            tick();
        end
        chk("ovf_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // push and pop together on a full FIFO
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(cw(i));
            wait_idle(20);
        end
        send(cw(4));
        chk("fp_start", 32'(dec_start), 1);
        tick();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fp_idle", 32'(busy), 0);
        chk("fp_ok", 32'(ok_cnt), 5);
        chk("fp_drop", 32'(drop_cnt), 0);
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            chk("fp_valid", 32'(out_valid), 1);
            chk("fp_data", 32'(out_data), 32'(val(i)));
            tick();
        end
        chk("fp_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // reset in the middle of a frame
        do_reset();
        send(15'h3ABC);
        tick();
        rst = 1'b1;
        rx_valid = 1'b1;
        rx_data = 15'h1111;
        tick();
        rst = 1'b0;
        rx_valid = 1'b0;
        chk("mr_busy", 32'(busy), 0);
        chk("mr_valid", 32'(out_valid), 0);
        chk("mr_decin", 32'(dec_in), 0);
        chk("mr_start", 32'(dec_start), 0);
        chk("mr_data", 32'(out_data), 0);
        chk("mr_ok", 32'(ok_cnt), 0);
        chk("mr_drop", 32'(drop_cnt), 0);
        tick();
        tick();
        tick();
        tick();
        chk("mr_still_idle", 32'(busy), 0);
        chk("mr_no_push", 32'(out_valid), 0);

        // long stream with saturation
        do_reset();
        out_ready = 1'b1;
        mon_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(cw(i));
            wait_idle(20);
        end
        tick();
        tick();
        mon_en = 1'b0;
        out_ready = 1'b0;
        chk("sat_ok", 32'(ok_cnt), 255);
        chk("sat_drop", 32'(drop_cnt), 0);
        chk("sat_count", 32'(got.size()), 300);
        for (int i = 0; i < 300; i++) begin
            if (i < got.size())
                chk("sat_order", 32'(got[i]), 32'(val(i)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
